dmem_seq: RTL and testbench

- Sequences one load/store from the pipeline MEM stage onto a variable-latency data-memory bus with a request/grant plus response-valid handshake.
- Performs the byte-lane masking, write-data lane shift and load sign/zero extension internally.
- Holds the pipeline stalled until the access completes, times out, or traps.
- Sits between the MEM stage and the data-memory or bus-interconnect port.

---
 rtl/dmem_seq_pkg.sv | 34 +++
 rtl/dmem_lane.sv | 43 ++++
 rtl/dmem_seq.sv | 167 ++++++++++++++++
 tb/tb_dmem_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_seq_pkg.sv
// Shared types and constants for the data-memory load/store sequencer.
// Optional feature macro: DMEM_SEQ_MISALIGN_TRAP_EN (misaligned half/word requests trap).
package dmem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4,
    ST_TRAP     = 3'd5
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H_LO = 4'b0011;
  localparam logic [3:0] MASK_H_HI = 4'b1100;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Half with odd address, or any word-sized access not on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic w_half;
    logic w_word;
    w_half = (funct3[1:0] == F3_H[1:0]);
    w_word = funct3[1];
    return (w_half & addr_lo[0]) | (w_word & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane logic: store mask, store data lane shift and load extraction/extension.
module dmem_lane
  import dmem_seq_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Access size decode; undefined encodings fall through to word.
  always_comb begin
    o_mask  = MASK_W;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    w_byte  = 8'(i_rdata >> {i_addr_lo, 3'b000});
    w_half  = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});
    case ({1'b0, i_funct3[1:0]})
      F3_B: begin
        o_mask  = 4'(MASK_B << i_addr_lo);
        o_wdata = i_wdata << {i_addr_lo, 3'b000};
        o_rdata = i_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        o_mask  = i_addr_lo[1] ? MASK_H_HI : MASK_H_LO;
        o_wdata = i_wdata << {i_addr_lo[1], 4'b0000};
        o_rdata = i_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_mask  = MASK_W;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_seq.sv
// MEM-stage load/store sequencer onto a req/gnt + rvalid data-memory bus.
// Optional feature macro: DMEM_SEQ_MISALIGN_TRAP_EN.
module dmem_seq
  import dmem_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned TIMEOUT_MAX = 200
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_valid,
  input  logic        i_mem_wen,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_wen,
  output logic [3:0]  o_bus_mask,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_trap
);

  state_e                r_state;
  logic                  r_wen;
  logic [2:0]            r_funct3;
  logic [31:0]           r_addr;
  logic [3:0]            r_mask;
  logic [31:0]           r_wdata;
  logic [TIMEOUT_W-1:0]  r_cnt;
  logic                  r_bus_req;
  logic                  r_done;
  logic                  r_err;
  logic [31:0]           r_rdata;

  logic                  w_idle;
  logic [2:0]            w_lane_f3;
  logic [1:0]            w_lane_lo;
  logic [3:0]            w_mask;
  logic [31:0]           w_wdata;
  logic [31:0]           w_rdata;
  logic [TIMEOUT_W-1:0]  w_cnt_nxt;
  logic                  w_timeout;
  logic                  w_misalign;

  // Lane logic sees the live request while idle, the latched one afterwards.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_lane_f3 = w_idle ? i_funct3 : r_funct3;
  assign w_lane_lo = w_idle ? i_addr[1:0] : r_addr[1:0];
  assign w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
  assign w_timeout = (w_cnt_nxt == TIMEOUT_W'(TIMEOUT_MAX));

  dmem_lane u_lane (
    .i_funct3  (w_lane_f3),
    .i_addr_lo (w_lane_lo),
    .i_wdata   (i_wdata),
    .i_rdata   (i_bus_rdata),
    .o_mask    (w_mask),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
  logic r_trap;
  assign w_misalign = is_misaligned(i_funct3, i_addr[1:0]);
  assign o_trap     = r_trap;
`else
  assign w_misalign = 1'b0;
  assign o_trap     = 1'b0;
`endif

  // Sequencer state, latched request and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_wen     <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= 32'h0;
      r_mask    <= 4'h0;
      r_wdata   <= 32'h0;
      r_cnt     <= '0;
      r_bus_req <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= 32'h0;
`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
      r_trap    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
      r_trap <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_mem_valid) begin
            if (w_misalign) begin
              r_state <= ST_TRAP;
`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
              r_trap  <= 1'b1;
`endif
            end else begin
              r_wen     <= i_mem_wen;
              r_funct3  <= i_funct3;
              r_addr    <= i_addr;
              r_mask    <= w_mask;
              r_wdata   <= w_wdata;
              r_cnt     <= '0;
              r_bus_req <= 1'b1;
              r_state   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_bus_gnt) begin
            r_bus_req <= 1'b0;
            r_cnt     <= '0;
            if (r_wen) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_WAIT_RSP;
            end
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= ST_ERR;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        ST_WAIT_RSP: begin
          if (i_bus_rvalid) begin
            r_rdata <= w_rdata;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_ERR;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall     = i_mem_valid & ~r_done & ~r_err & ~o_trap;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_bus_req   = r_bus_req;
  assign o_bus_addr  = {r_addr[31:2], 2'b00};
  assign o_bus_wen   = r_wen;
  assign o_bus_mask  = r_mask;
  assign o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_seq.sv
// Directed self-checking bench for dmem_seq.
module tb_dmem_seq;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_wen;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata_o;
  logic        err;
  logic        bus_req;
  logic        gnt;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [3:0]  bus_mask;
  logic [31:0] bus_wdata;
  logic        rvalid;
  logic [31:0] bus_rdata;
  logic        trap;

  int n_checks = 0;
  int n_pass   = 0;

  int          a_done;
  int          a_err;
  int          a_lat;
  int          a_stall_bad;
  logic [31:0] a_rd;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_mask;
  logic        a_wen;
  int          pulses;

  dmem_seq dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mem_valid  (mem_valid),
    .i_mem_wen    (mem_wen),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_stall      (stall),
    .o_done       (done),
    .o_rdata      (rdata_o),
    .o_err        (err),
    .o_bus_req    (bus_req),
    .i_bus_gnt    (gnt),
    .o_bus_addr   (bus_addr),
    .o_bus_wen    (bus_wen),
    .o_bus_mask   (bus_mask),
    .o_bus_wdata  (bus_wdata),
    .i_bus_rvalid (rvalid),
    .i_bus_rdata  (bus_rdata),
    .o_trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One access: gnt after gnt_dly request cycles, rvalid after rsp_dly wait cycles (-1 = never).
  task automatic access(input logic wen_i, input logic [2:0] f3_i, input logic [31:0] addr_i,
                        input logic [31:0] wdata_i, input int gnt_dly, input int rsp_dly,
                        input logic [31:0] rdat_i);
    int  req_cyc;
    int  rsp_cyc;
    int  post;
    bit  granted;
    bit  fin;
    req_cyc = 0; rsp_cyc = 0; post = 0; granted = 0; fin = 0;
    a_done = 0; a_err = 0; a_lat = 0; a_stall_bad = 0;
    a_rd = 32'h0; a_addr = 32'h0; a_wdata = 32'h0; a_mask = 4'h0; a_wen = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; mem_wen = wen_i; funct3 = f3_i; addr = addr_i; wdata = wdata_i;
    gnt = 1'b0; rvalid = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (!fin) begin
        if (done || err) begin
          if (stall) a_stall_bad++;
        end else if (!stall) begin
          a_stall_bad++;
        end
      end
      if (done) begin
        a_done++;
        if (!fin) begin a_rd = rdata_o; a_lat = c; end
      end
      if (err) begin
        a_err++;
        if (!fin) a_lat = c;
      end
      gnt = 1'b0; rvalid = 1'b0;
      if (fin) begin
        post++;
        if (post >= 3) break;
      end else if (done || err) begin
        fin = 1; mem_valid = 1'b0;
      end else if (bus_req) begin
        if (req_cyc == gnt_dly) begin
          gnt = 1'b1; granted = 1;
          a_addr = bus_addr; a_wdata = bus_wdata; a_mask = bus_mask; a_wen = bus_wen;
        end
        req_cyc++;
      end else if (granted && !wen_i) begin
        if (rsp_cyc == rsp_dly) begin rvalid = 1'b1; bus_rdata = rdat_i; end
        rsp_cyc++;
      end
    end
    mem_valid = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    chk("access_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_wen = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; gnt = 1'b0; rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_req",     32'(bus_req), 32'd0);
    chk("rst_rdata",   rdata_o,      32'h0);
    chk("rst_stall",   32'(stall),   32'd0);
    chk("rst_trap",    32'(trap),    32'd0);
    chk("rst_mask",    32'(bus_mask), 32'h0);
    chk("rst_addr",    bus_addr,     32'h0);
    chk("rst_wdata",   bus_wdata,    32'h0);
    rst_n = 1'b1;

    // SB 0x1003 <- 0xAB, immediate grant
    access(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, -1, 32'h0);
    chk("sb_mask",  32'(a_mask), 32'h8);
    chk("sb_wdata", a_wdata,     32'hAB00_0000);
    chk("sb_addr",  a_addr,      32'h0000_1000);
    chk("sb_wen",   32'(a_wen),  32'd1);
    chk("sb_lat",   32'(a_lat),  32'd2);
    chk("sb_done",  32'(a_done), 32'd1);
    chk("sb_err",   32'(a_err),  32'd0);
    chk("sb_stall", 32'(a_stall_bad), 32'd0);

    // LB / LBU 0x2002, gnt after 2, rvalid 3 later
    access(1'b0, 3'b000, 32'h0000_2002, 32'h0, 2, 3, 32'h0080_0000);
    chk("lb_mask",  32'(a_mask), 32'h4);
    chk("lb_addr",  a_addr,      32'h0000_2000);
    chk("lb_rdata", a_rd,        32'hFFFF_FF80);
    chk("lb_lat",   32'(a_lat),  32'd8);
    chk("lb_done",  32'(a_done), 32'd1);
    chk("lb_stall", 32'(a_stall_bad), 32'd0);
    access(1'b0, 3'b100, 32'h0000_2002, 32'h0, 2, 3, 32'h0080_0000);
    chk("lbu_rdata", a_rd,        32'h0000_0080);
    chk("lbu_done",  32'(a_done), 32'd1);

    // LH / LHU 0x2002, minimum latency
    access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234);
    chk("lh_mask",  32'(a_mask), 32'hC);
    chk("lh_rdata", a_rd,        32'hFFFF_8001);
    chk("lh_lat",   32'(a_lat),  32'd3);
    access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'h8001_1234);
    chk("lhu_rdata", a_rd,       32'h0000_8001);

    // Stray gnt/rvalid while idle are ignored
    @(negedge clk);
    gnt = 1'b1; rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || err || bus_req) pulses++;
    end
    gnt = 1'b0; rvalid = 1'b0;
    chk("stray_pulses", 32'(pulses), 32'd0);
    chk("stray_rdata",  rdata_o,     32'h0000_8001);

    // Load response timeout
    access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 0, -1, 32'h0);
    chk("tmo_err",   32'(a_err),  32'd1);
    chk("tmo_done",  32'(a_done), 32'd0);
    chk("tmo_lat",   32'(a_lat),  32'd202);
    chk("tmo_stall", 32'(a_stall_bad), 32'd0);
    chk("tmo_rdata", rdata_o,     32'h0000_8001);

    // Store after timeout
    access(1'b1, 3'b010, 32'h0000_4004, 32'hDEAD_BEEF, 1, -1, 32'h0);
    chk("sw_mask",  32'(a_mask), 32'hF);
    chk("sw_wdata", a_wdata,     32'hDEAD_BEEF);
    chk("sw_addr",  a_addr,      32'h0000_4004);
    chk("sw_lat",   32'(a_lat),  32'd3);
    chk("sw_done",  32'(a_done), 32'd1);

    // rvalid on the last allowed wait cycle
    access(1'b0, 3'b010, 32'h0000_5000, 32'h0, 0, 199, 32'h1234_5678);
    chk("edge_done",  32'(a_done), 32'd1);
    chk("edge_err",   32'(a_err),  32'd0);
    chk("edge_lat",   32'(a_lat),  32'd202);
    chk("edge_rdata", a_rd,        32'h1234_5678);

    // Grant never arrives
    access(1'b1, 3'b010, 32'h0000_5004, 32'h1, -1, -1, 32'h0);
    chk("gtmo_err",  32'(a_err),  32'd1);
    chk("gtmo_done", 32'(a_done), 32'd0);
    chk("gtmo_lat",  32'(a_lat),  32'd201);

    // SH upper half
    access(1'b1, 3'b001, 32'h0000_6002, 32'h0000_BEEF, 0, -1, 32'h0);
    chk("sh_mask",  32'(a_mask), 32'hC);
    chk("sh_wdata", a_wdata,     32'hBEEF_0000);

`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
    // Misaligned LW traps without touching the bus
    @(negedge clk);
    mem_valid = 1'b1; mem_wen = 1'b0; funct3 = 3'b010; addr = 32'h0000_3002;
    @(negedge clk);
    chk("trap_pulse", 32'(trap),    32'd1);
    chk("trap_stall", 32'(stall),   32'd0);
    chk("trap_req",   32'(bus_req), 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    chk("trap_clear", 32'(trap),    32'd0);
    chk("trap_req2",  32'(bus_req), 32'd0);
`else
    // Misaligned half at byte 3 and misaligned word proceed on the bus
    access(1'b1, 3'b001, 32'h0000_6003, 32'h0000_BEEF, 0, -1, 32'h0);
    chk("msh_mask",  32'(a_mask), 32'hC);
    chk("msh_wdata", a_wdata,     32'hBEEF_0000);
    access(1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'hCAFE_F00D);
    chk("mlw_mask",  32'(a_mask), 32'hF);
    chk("mlw_addr",  a_addr,      32'h0000_3000);
    chk("mlw_rdata", a_rd,        32'hCAFE_F00D);
    chk("mlw_trap",  32'(trap),   32'd0);
`endif

    // Async reset while waiting for the response
    @(negedge clk);
    mem_valid = 1'b1; mem_wen = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000;
    @(negedge clk);
    chk("arst_req_seen", 32'(bus_req), 32'd1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("arst_wait_req", 32'(bus_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rdata", rdata_o,     32'h0);
    chk("arst_done",  32'(done),   32'd0);
    mem_valid = 1'b0; rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || err || bus_req) pulses++;
    end
    rvalid = 1'b0;
    chk("arst_no_pulse", 32'(pulses), 32'd0);
    chk("arst_rdata2",   rdata_o,     32'h0);

    // Async reset during REQ drops the request immediately
    @(negedge clk);
    mem_valid = 1'b1; mem_wen = 1'b1; funct3 = 3'b010; addr = 32'h0000_8000; wdata = 32'h1;
    @(negedge clk);
    chk("arst2_req_seen", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_req_drop", 32'(bus_req), 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst2_done", 32'(done), 32'd0);

    // Recovery after reset
    access(1'b1, 3'b000, 32'h0000_9001, 32'h0000_005A, 0, -1, 32'h0);
    chk("rec_mask",  32'(a_mask), 32'h2);
    chk("rec_wdata", a_wdata,     32'h0000_5A00);
    chk("rec_lat",   32'(a_lat),  32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
